// File: rtl/disp_to_dec_monitor_if.sv
// Segment-bus sample interface: an active-low 7-segment pattern plus the digit position it drives.
interface disp_to_dec_monitor_if #(
    parameter int IDX_W = 1
);
    logic [6:0]       disp;
    logic             disp_valid;
    logic [IDX_W-1:0] digit_idx;

    modport master (output disp, output disp_valid, output digit_idx);
    modport slave  (input  disp, input  disp_valid, input  digit_idx);
endinterface

// File: rtl/disp_to_dec_monitor.sv
// Watches a multiplexed active-low seven-segment bus and recovers debounced 4-bit digit values.
module disp_to_dec_monitor #(
    parameter int NUM_DIGITS   = 2,
    parameter int STABLE_COUNT = 3,
    parameter int IDX_W        = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    disp_to_dec_monitor_if.slave    seg_bus,
    output logic [4*NUM_DIGITS-1:0] dec,
    output logic [NUM_DIGITS-1:0]   dec_valid,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic                    update,
    output logic                    bad_code
);

    localparam int KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [3:0] STABLE = 4'(STABLE_COUNT);

    logic             s1_valid;
    logic [6:0]       s1_disp;
    logic [IDX_W-1:0] s1_idx;

    // Candidate codes are 5 bits: bit 4 marks blank, bits 3..0 hold the hex value.
    logic [4:0] cand  [NUM_DIGITS];
    logic [3:0] cnt   [NUM_DIGITS];
    logic [3:0] dec_r [NUM_DIGITS];

    logic [KW-1:0] k;
    logic [31:0]   idx_wide;
    logic          idx_ok;
    logic          code_ok;
    logic [4:0]    code;
    logic          same;
    logic [3:0]    next_cnt;
    logic          commit;
    logic [3:0]    new_val;
    logic          new_blank;
    logic          changed;

    // Returns {recognised, blank, value}.
    function automatic logic [5:0] decode(input logic [6:0] p);
        case (p)
            7'b1000000: return 6'b100000;
            7'b1111001: return 6'b100001;
            7'b0100100: return 6'b100010;
            7'b0110000: return 6'b100011;
            7'b0011001: return 6'b100100;
            7'b0010010: return 6'b100101;
            7'b0000010: return 6'b100110;
            7'b1111000: return 6'b100111;
            7'b0000000: return 6'b101000;
            7'b0011000: return 6'b101001;
            7'b0001000: return 6'b101010;
            7'b0000011: return 6'b101011;
            7'b1000110: return 6'b101100;
            7'b0100001: return 6'b101101;
            7'b0000110: return 6'b101110;
            7'b0001110: return 6'b101111;
            7'b1111111: return 6'b110000;
            default:    return 6'b000000;
        endcase
    endfunction

    assign k        = s1_idx[KW-1:0];
    assign idx_wide = 32'(s1_idx);
    assign idx_ok   = idx_wide < 32'(NUM_DIGITS);

    always_comb begin
        {code_ok, code} = decode(s1_disp);
        same            = (code == cand[k]) && (cnt[k] != 4'd0);
        next_cnt        = 4'd1;
        if (same) begin
            next_cnt = (cnt[k] < STABLE) ? cnt[k] + 4'd1 : cnt[k];
        end
        // A saturated counter seeing the same code is not a new confirmation.
        commit    = (next_cnt == STABLE) && !(same && (cnt[k] == STABLE));
        new_blank = code[4];
        new_val   = code[4] ? 4'd0 : code[3:0];
        changed   = !dec_valid[k] || (dec_r[k] != new_val) || (blank[k] != new_blank);
    end

    always_comb begin
        dec = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dec[4*i +: 4] = dec_r[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_disp   <= '0;
            s1_idx    <= '0;
            dec_valid <= '0;
            blank     <= '0;
            update    <= 1'b0;
            bad_code  <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                cand[i]  <= '0;
                cnt[i]   <= '0;
                dec_r[i] <= '0;
            end
        end else begin
            s1_valid <= seg_bus.disp_valid;
            if (seg_bus.disp_valid) begin
                s1_disp <= seg_bus.disp;
                s1_idx  <= seg_bus.digit_idx;
            end
            update   <= 1'b0;
            bad_code <= 1'b0;
            if (s1_valid) begin
                if (!idx_ok) begin
                    bad_code <= 1'b1;
                end else if (!code_ok) begin
                    bad_code <= 1'b1;
                    cnt[k]   <= 4'd0;
                end else begin
                    cand[k] <= code;
                    cnt[k]  <= next_cnt;
                    if (commit) begin
                        dec_r[k]     <= new_val;
                        blank[k]     <= new_blank;
                        dec_valid[k] <= 1'b1;
                        update       <= changed;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_disp_to_dec_monitor.sv
// Directed self-checking bench for disp_to_dec_monitor with two digits and a three-sample debounce.
module tb_disp_to_dec_monitor;

    localparam int NUM_DIGITS   = 2;
    localparam int STABLE_COUNT = 3;
    localparam int IDX_W        = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [4*NUM_DIGITS-1:0] dec;
    logic [NUM_DIGITS-1:0]   dec_valid;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    update;
    logic                    bad_code;

    int tests_run    = 0;
    int tests_failed = 0;
    int update_seen  = 0;
    int bad_seen     = 0;
    int upd0;
    int bad0;

    disp_to_dec_monitor_if #(.IDX_W(IDX_W)) seg_bus ();

    disp_to_dec_monitor #(
        .NUM_DIGITS  (NUM_DIGITS),
        .STABLE_COUNT(STABLE_COUNT),
        .IDX_W       (IDX_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .seg_bus  (seg_bus.slave),
        .dec      (dec),
        .dec_valid(dec_valid),
        .blank    (blank),
        .update   (update),
        .bad_code (bad_code)
    );

    always #5 clk = ~clk;

    // Pulses are tallied on the edge after they appear, so read the tallies only after idling.
    always @(posedge clk) begin
        if (update)   update_seen <= update_seen + 1;
        if (bad_code) bad_seen    <= bad_seen + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        tests_run++;
        if (got !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expected);
        end
    endtask

    task automatic applyStimulus(input logic [IDX_W-1:0] idx, input logic [6:0] pat);
        @(negedge clk);
        seg_bus.disp_valid = 1'b1;
        seg_bus.disp       = pat;
        seg_bus.digit_idx  = idx;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            seg_bus.disp_valid = 1'b0;
        end
    endtask

    initial begin
        seg_bus.disp       = 7'h7f;
        seg_bus.disp_valid = 1'b0;
        seg_bus.digit_idx  = '0;
        reset              = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_dec",       32'(dec),       32'h0);
        checkOutput("rst_dec_valid", 32'(dec_valid), 32'h0);
        checkOutput("rst_blank",     32'(blank),     32'h0);
        checkOutput("rst_update",    32'(update),    32'h0);
        checkOutput("rst_bad_code",  32'(bad_code),  32'h0);
        reset = 1'b0;
        idle(2);

        // Digit 0 confirmed as 3 after three strobes, visible two edges after the last one.
        upd0 = update_seen;
        repeat (3) applyStimulus(2'd0, 7'b0110000);
        idle(1);
        checkOutput("t1_not_yet",    32'(dec_valid), 32'h0);
        idle(1);
        checkOutput("t1_dec0",       32'(dec[3:0]),  32'h3);
        checkOutput("t1_dec_valid",  32'(dec_valid), 32'h1);
        checkOutput("t1_update",     32'(update),    32'h1);
        applyStimulus(2'd0, 7'b0110000);
        idle(4);
        checkOutput("t1_update_cnt", 32'(update_seen - upd0), 32'h1);
        checkOutput("t1_dec_hold",   32'(dec),       32'h03);

        // Digit 1: an interrupted 5 then a stable 6.
        upd0 = update_seen;
        repeat (2) applyStimulus(2'd1, 7'b0010010);
        idle(3);
        checkOutput("t2_no_commit",  32'(dec_valid), 32'h1);
        repeat (3) applyStimulus(2'd1, 7'b0000010);
        idle(3);
        checkOutput("t2_dec1",       32'(dec[7:4]),  32'h6);
        checkOutput("t2_dec0",       32'(dec[3:0]),  32'h3);
        checkOutput("t2_dec_valid",  32'(dec_valid), 32'h3);
        checkOutput("t2_update_cnt", 32'(update_seen - upd0), 32'h1);

        // Digit 0 confirmed as 2, then as blank.
        repeat (3) applyStimulus(2'd0, 7'b0100100);
        idle(3);
        checkOutput("t3_dec0_two",   32'(dec[3:0]),  32'h2);
        upd0 = update_seen;
        repeat (3) applyStimulus(2'd0, 7'b1111111);
        idle(3);
        checkOutput("t3_blank",      32'(blank),     32'h1);
        checkOutput("t3_dec0",       32'(dec[3:0]),  32'h0);
        checkOutput("t3_dec_valid",  32'(dec_valid), 32'h3);
        checkOutput("t3_update_cnt", 32'(update_seen - upd0), 32'h1);

        // An invalid pattern restarts the debounce on digit 0.
        upd0 = update_seen;
        bad0 = bad_seen;
        applyStimulus(2'd0, 7'b0100100);
        applyStimulus(2'd0, 7'b0100100);
        applyStimulus(2'd0, 7'b1010101);
        applyStimulus(2'd0, 7'b0100100);
        idle(3);
        checkOutput("t4_bad_cnt",    32'(bad_seen - bad0),    32'h1);
        checkOutput("t4_no_commit",  32'(update_seen - upd0), 32'h0);
        checkOutput("t4_dec0_hold",  32'(dec[3:0]),  32'h0);
        checkOutput("t4_blank_hold", 32'(blank),     32'h1);
        repeat (2) applyStimulus(2'd0, 7'b0100100);
        idle(3);
        checkOutput("t4_dec0",       32'(dec[3:0]),  32'h2);
        checkOutput("t4_blank",      32'(blank),     32'h0);
        checkOutput("t4_update_cnt", 32'(update_seen - upd0), 32'h1);

        // Out-of-range index must not disturb digit 0's partial count.
        upd0 = update_seen;
        bad0 = bad_seen;
        repeat (2) applyStimulus(2'd0, 7'b0000000);
        applyStimulus(2'd2, 7'b1000000);
        idle(3);
        checkOutput("t5_bad_cnt",    32'(bad_seen - bad0),    32'h1);
        checkOutput("t5_dec",        32'(dec),       32'h62);
        checkOutput("t5_dec_valid",  32'(dec_valid), 32'h3);
        checkOutput("t5_no_update",  32'(update_seen - upd0), 32'h0);
        applyStimulus(2'd0, 7'b0000000);
        idle(3);
        checkOutput("t5_dec0",       32'(dec[3:0]),  32'h8);
        checkOutput("t5_update_cnt", 32'(update_seen - upd0), 32'h1);

        // Reset in the middle of a count discards it.
        repeat (2) applyStimulus(2'd0, 7'b1111000);
        idle(2);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("t6_dec",        32'(dec),       32'h0);
        checkOutput("t6_dec_valid",  32'(dec_valid), 32'h0);
        checkOutput("t6_blank",      32'(blank),     32'h0);
        checkOutput("t6_update",     32'(update),    32'h0);
        checkOutput("t6_bad_code",   32'(bad_code),  32'h0);
        reset = 1'b0;
        idle(1);
        upd0 = update_seen;
        applyStimulus(2'd0, 7'b1111000);
        idle(4);
        checkOutput("t6_no_commit",  32'(dec_valid), 32'h0);
        checkOutput("t6_dec_after",  32'(dec),       32'h0);
        checkOutput("t6_no_update",  32'(update_seen - upd0), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/disp_to_dec_monitor.md
Name: disp_to_dec_monitor

Overview:
- Receive-side counterpart of the hex-to-seven-segment decoder: watches the multiplexed active-low segment bus driving the shot-clock display and recovers each digit's 4-bit value.
- Each digit is debounced: it must decode to the same value on STABLE_COUNT consecutive samples before it is confirmed.
- Used for display self-check and for loopback verification of the shot-clock output path.

Parameters:
- NUM_DIGITS, 2, number of multiplexed digits observed; legal range 1..8.
- STABLE_COUNT, 3, consecutive identical samples needed to confirm a digit; legal range 1..15.
- IDX_W, 1, width of digit_idx; must be at least clog2(NUM_DIGITS) and at least 1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- disp  in  7  active-low segment pattern; bit0=a … bit6=g (0 lights the segment)
- disp_valid  in  1  sample strobe; disp and digit_idx are meaningful only when high
- digit_idx  in  IDX_W  digit position currently driven
- dec  out  4*NUM_DIGITS  confirmed values; digit k occupies bits [4k+3:4k]
- dec_valid  out  NUM_DIGITS  bit k high once digit k has been confirmed at least once
- blank  out  NUM_DIGITS  bit k high when digit k is confirmed as blank (all segments off)
- update  out  1  one-cycle pulse when any confirmed value or blank flag changes
- bad_code  out  1  one-cycle pulse for an unrecognised pattern or an out-of-range digit_idx

Behaviour:
- Reset: dec=0, dec_valid=0, blank=0, update=0, bad_code=0. Every candidate is cleared to 0 and every counter to 0; the stage-1 register valid bit is cleared. Reset applied mid-operation discards all partial counts.
- Stage 1 (capture): when disp_valid=1, register disp and digit_idx and set the s1 valid bit. Otherwise the s1 valid bit is 0.
- Stage 2 (decode/compare): acts on the registered sample.
- Latency: a sample whose strobe is high in cycle t can change the outputs after the clock edge ending cycle t+1, i.e. 2 clock edges from the strobe.
- Decode table (patterns as bits 6..0) is the exact inverse of the display encoder:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - 1111111 = blank
  - Any other pattern is invalid.
- Out-of-range index: if s1 idx >= NUM_DIGITS, pulse bad_code and change no state.
- Invalid pattern: pulse bad_code, clear that digit's counter to 0, leave its candidate and confirmed outputs unchanged.
- Valid code C (16 values plus blank, held as a 5-bit code) on digit k:
  - If C equals candidate[k] and counter[k] > 0: counter[k] increments, saturating at STABLE_COUNT.
  - Otherwise: candidate[k]=C, counter[k]=1.
- Commit happens in the same cycle the counter reaches STABLE_COUNT (transition only, not while it is saturated):
  - Write dec[k] (0 when blank), blank[k] and dec_valid[k]=1.
  - Pulse update only if dec_valid[k] was 0 or the committed value or blank flag differs from the stored one.
- STABLE_COUNT=1: every valid sample commits immediately.
- Saturated counter: repeated identical samples cause no further commits and no update pulses.
- A changed value interrupts the count and restarts it at 1; confirmed outputs hold their old value until the new value is confirmed.
- At most one digit is processed per cycle, so update and bad_code never pulse for two events in the same cycle.
- Back-to-back strobes on every cycle are supported with no stalls; there is no backpressure.

Test Plan:
- Reset, then digit0 ← 0110000 for 3 consecutive strobes → after the 3rd, 2 edges later: dec[3:0]=3, dec_valid=01, one update pulse; a 4th identical strobe produces no update.
- Digit1 ← 0010010, 0010010, 0000010, 0000010, 0000010 → no commit on the first two samples; dec[7:4]=6 after the 5th sample; dec[3:0] untouched.
- Digit0 confirmed as 2, then 3 strobes of 1111111 → blank=01, dec[3:0]=0, dec_valid[0]=1, one update pulse.
- Digit0 ← 0100100, 0100100, 1010101, 0100100 → bad_code pulses once on the 3rd sample; no commit; two more 0100100 strobes then commit dec[3:0]=2.
- digit_idx=2 with NUM_DIGITS=2 and disp=1000000 → bad_code pulse; dec, dec_valid and counters unchanged.
- Assert reset while digit0 has 2 of 3 matching samples of 7 (1111000) → all outputs 0; one further 1111000 strobe does not commit.
